uart_cfg: RTL and testbench

- Parametrised full-duplex UART, successor to the fixed 8N1 UART.
- Contains independent TX and RX state machines.
- Data width and stop-bit count are build-time parameters. Parity enable/sense and the bit period are run-time inputs.
- Adds parity-error and framing-error reporting and a TX busy flag. Sits between a host-side register interface and the board serial pins.

---
 rtl/uart_cfg.sv | 197 +++++++++++++++++++
 tb/tb_uart_cfg.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg.sv
// uart_cfg: full-duplex UART, build-time width/stop bits, run-time parity
// and bit period latched per frame; parity/framing errors and TX busy/done.
module uart_cfg #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int BAUD_W    = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BAUD_W-1:0]    baud_goal,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 TX,
    output logic                 tx_busy,
    output logic                 tx_done,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_rdy,
    input  logic                 clr_rx_rdy,
    output logic                 parity_err,
    output logic                 frame_err
);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               tx_state, tx_next;
    logic [BAUD_W-1:0]    tx_cnt, tx_baud;
    logic [IDX_W-1:0]     tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par_en, tx_par;
    logic                 tx_tick, tx_load;

    assign tx_tick = (tx_cnt == '0);

    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        unique case (tx_state)
            IDLE: if (trmt) begin
                tx_next = START;
                tx_load = 1'b1;
            end
            START: if (tx_tick) tx_next = DATA;
            DATA: if (tx_tick && tx_idx == LAST_DATA)
                tx_next = tx_par_en ? PARITY : STOP;
            PARITY: if (tx_tick) tx_next = STOP;
            // a request on the last stop cycle chains straight into a new frame
            STOP: if (tx_tick && tx_idx == LAST_STOP) begin
                tx_next = trmt ? START : IDLE;
                tx_load = trmt;
            end
            default: tx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= IDLE;
        else        tx_state <= tx_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            TX        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            tx_cnt    <= '0;
            tx_baud   <= '0;
            tx_idx    <= '0;
            tx_shift  <= '0;
            tx_par_en <= 1'b0;
            tx_par    <= 1'b0;
        end else if (tx_load) begin
            TX        <= 1'b0;
            tx_busy   <= 1'b1;
            tx_done   <= 1'b0;
            tx_cnt    <= baud_goal - 1'b1;
            tx_baud   <= baud_goal;
            tx_idx    <= '0;
            tx_shift  <= tx_data;
            tx_par_en <= parity_en;
            tx_par    <= (^tx_data) ^ parity_odd;
        end else if (tx_state != IDLE) begin
            if (tx_tick) begin
                tx_cnt <= tx_baud - 1'b1;
                tx_idx <= (tx_next == tx_state) ? tx_idx + 1'b1 : '0;
                unique case (tx_next)
                    DATA: begin
                        TX       <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                    PARITY: TX <= tx_par;
                    STOP:   TX <= 1'b1;
                    default: begin
                        TX      <= 1'b1;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end
                endcase
            end else begin
                tx_cnt <= tx_cnt - 1'b1;
            end
        end
    end

    state_t               rx_state, rx_next;
    logic [BAUD_W-1:0]    rx_cnt, rx_baud;
    logic [IDX_W-1:0]     rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_s1, rx_s2, rx_q;
    logic                 rx_par_en, rx_par_odd, rx_par_bit;
    logic                 rx_tick, rx_fall, rx_go, rx_fin;

    assign rx_tick = (rx_cnt == '0);
    assign rx_fall = rx_q & ~rx_s2;

    always_comb begin
        rx_next = rx_state;
        rx_go   = 1'b0;
        rx_fin  = 1'b0;
        unique case (rx_state)
            IDLE: if (rx_fall) begin
                rx_next = START;
                rx_go   = 1'b1;
            end
            START: if (rx_tick) rx_next = rx_s2 ? IDLE : DATA;
            DATA: if (rx_tick && rx_idx == LAST_DATA)
                rx_next = rx_par_en ? PARITY : STOP;
            PARITY: if (rx_tick) rx_next = STOP;
            STOP: if (rx_tick) begin
                rx_next = IDLE;
                rx_fin  = 1'b1;
            end
            default: rx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= IDLE;
        else        rx_state <= rx_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_q       <= 1'b1;
            rx_cnt     <= '0;
            rx_baud    <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_par_bit <= 1'b0;
            rx_data    <= '0;
            rx_rdy     <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            rx_q  <= rx_s2;
            // later assignments override, so a completing frame beats a clear
            if (clr_rx_rdy) rx_rdy <= 1'b0;
            if (rx_go) begin
                rx_cnt     <= (baud_goal >> 1) - 1'b1;
                rx_baud    <= baud_goal;
                rx_idx     <= '0;
                rx_par_en  <= parity_en;
                rx_par_odd <= parity_odd;
                rx_rdy     <= 1'b0;
            end else if (rx_state != IDLE) begin
                if (rx_tick) begin
                    rx_cnt <= rx_baud - 1'b1;
                    if (rx_state == DATA) begin
                        rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                        rx_idx   <= rx_idx + 1'b1;
                    end
                    if (rx_state == PARITY) rx_par_bit <= rx_s2;
                    if (rx_fin) begin
                        rx_data    <= rx_shift;
                        parity_err <= rx_par_en &
                                      (rx_par_bit ^ (^rx_shift) ^ rx_par_odd);
                        frame_err  <= ~rx_s2;
                        rx_rdy     <= 1'b1;
                    end
                end else begin
                    rx_cnt <= rx_cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg: loopback frames, driven RX error frames,
// rx_rdy clear/set priority, mid-frame reset and a 7-bit/2-stop build.
module tb_uart_cfg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic [13:0] baud_goal = 14'd16;
    logic        parity_en = 1'b0, parity_odd = 1'b0;
    logic        trmt = 1'b0, trmt7 = 1'b0;
    logic [7:0]  tx_data = '0;
    logic [6:0]  tx_data7 = '0;
    logic        loop = 1'b1, rx_drv = 1'b1, clr_rx_rdy = 1'b0;
    logic        TX, tx_busy, tx_done, rx_rdy, parity_err, frame_err;
    logic [7:0]  rx_data;
    logic        TX7, tx_busy7, tx_done7, rx_rdy7, parity_err7, frame_err7;
    logic [6:0]  rx_data7;
    logic        rx_line;

    assign rx_line = loop ? TX : rx_drv;

    uart_cfg u_dut (
        .clk(clk), .rst_n(rst_n), .baud_goal(baud_goal),
        .parity_en(parity_en), .parity_odd(parity_odd),
        .trmt(trmt), .tx_data(tx_data), .TX(TX),
        .tx_busy(tx_busy), .tx_done(tx_done), .RX(rx_line),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy),
        .parity_err(parity_err), .frame_err(frame_err)
    );

    uart_cfg #(.DATA_BITS(7), .STOP_BITS(2)) u_dut7 (
        .clk(clk), .rst_n(rst_n), .baud_goal(baud_goal),
        .parity_en(parity_en), .parity_odd(parity_odd),
        .trmt(trmt7), .tx_data(tx_data7), .TX(TX7),
        .tx_busy(tx_busy7), .tx_done(tx_done7), .RX(TX7),
        .rx_data(rx_data7), .rx_rdy(rx_rdy7), .clr_rx_rdy(1'b0),
        .parity_err(parity_err7), .frame_err(frame_err7)
    );

    int errors = 0;
    int checks = 0;
    logic w_tx[512], w_dn[512], w_bz[512];
    logic w_tx7[512], w_dn7[512], w_bz7[512];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic sel, input logic [7:0] d);
        @(negedge clk);
        if (sel) begin
            trmt7 = 1'b1;
            tx_data7 = d[6:0];
        end else begin
            trmt = 1'b1;
            tx_data = d;
        end
        @(negedge clk);
        trmt = 1'b0;
        trmt7 = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            w_tx[i] = TX;   w_dn[i] = tx_done;   w_bz[i] = tx_busy;
            w_tx7[i] = TX7; w_dn7[i] = tx_done7; w_bz7[i] = tx_busy7;
            @(negedge clk);
        end
    endtask

    // bits: full frame LSB first (start, data, parity, stops)
    task automatic check_wave(input string tag, input logic sel,
                              input logic [15:0] bits, input int nb);
        int len;
        len = nb * 16;
        for (int j = 0; j < nb; j++) begin
            check($sformatf("%s_bit%0d_first", tag, j),
                  sel ? w_tx7[16*j] : w_tx[16*j], bits[j]);
            check($sformatf("%s_bit%0d_last", tag, j),
                  sel ? w_tx7[16*j+15] : w_tx[16*j+15], bits[j]);
        end
        check({tag, "_done_pre"}, sel ? w_dn7[len-1] : w_dn[len-1], 0);
        check({tag, "_done"}, sel ? w_dn7[len] : w_dn[len], 1);
        check({tag, "_busy_pre"}, sel ? w_bz7[len-1] : w_bz[len-1], 1);
        check({tag, "_busy_end"}, sel ? w_bz7[len] : w_bz[len], 0);
    endtask

    task automatic drive_bits(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            rx_drv = v[i];
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic check_rx(input string tag, input logic [7:0] d,
                            input logic rdy, input logic pe, input logic fe);
        check({tag, "_data"}, rx_data, d);
        check({tag, "_rdy"}, rx_rdy, rdy);
        check({tag, "_perr"}, parity_err, pe);
        check({tag, "_ferr"}, frame_err, fe);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", TX, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check_rx("rst", 8'h00, 0, 0, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send(0, 8'hA5);
        capture(162);
        check_wave("a5", 0, {1'b1, 8'hA5, 1'b0}, 10);
        check_rx("a5_rx", 8'hA5, 1, 0, 0);

        send(0, 8'h5A);
        fork
            capture(162);
            begin
                repeat (50) @(negedge clk);
                trmt = 1'b1;
                tx_data = 8'hFF;
                @(negedge clk);
                trmt = 1'b0;
            end
        join
        check_wave("midtrmt", 0, {1'b1, 8'h5A, 1'b0}, 10);
        check_rx("midtrmt_rx", 8'h5A, 1, 0, 0);

        parity_en = 1'b1;
        send(0, 8'h07);
        capture(178);
        check_wave("par_even", 0, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
        check_rx("par_even_rx", 8'h07, 1, 0, 0);

        parity_odd = 1'b1;
        send(0, 8'h07);
        capture(178);
        check_wave("par_odd", 0, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
        check_rx("par_odd_rx", 8'h07, 1, 0, 0);

        parity_odd = 1'b0;
        loop = 1'b0;
        drive_bits({1'b1, 1'b0, 8'h07, 1'b0}, 11);
        repeat (4) @(negedge clk);
        check_rx("par_flip", 8'h07, 1, 1, 0);

        parity_en = 1'b0;
        loop = 1'b1;
        send(0, 8'hC3);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx", TX, 1);
        check("midrst_busy", tx_busy, 0);
        check("midrst_done", tx_done, 0);
        check_rx("midrst", 8'h00, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send(0, 8'h96);
        capture(162);
        check_wave("post_rst", 0, {1'b1, 8'h96, 1'b0}, 10);
        check_rx("post_rst_rx", 8'h96, 1, 0, 0);

        loop = 1'b0;
        drive_bits({1'b0, 8'h3C, 1'b0}, 10);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        check_rx("bad_stop", 8'h3C, 1, 0, 1);

        drive_bits(16'h0000, 1);
        check("start_clr_rdy", rx_rdy, 0);
        check("start_hold_ferr", frame_err, 1);
        drive_bits({1'b1, 8'h81}, 9);
        repeat (4) @(negedge clk);
        check_rx("clean", 8'h81, 1, 0, 0);

        clr_rx_rdy = 1'b1;
        @(negedge clk);
        clr_rx_rdy = 1'b0;
        check("clr_rdy", rx_rdy, 0);
        rx_drv = 1'b0;
        repeat (5) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check_rx("glitch", 8'h81, 0, 0, 0);

        drive_bits({8'h5A, 1'b0}, 9);
        rx_drv = 1'b1;
        clr_rx_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rx_rdy) break;
        end
        clr_rx_rdy = 1'b0;
        check("set_wins", rx_rdy, 1);
        @(negedge clk);
        check_rx("set_wins_hold", 8'h5A, 1, 0, 0);
        repeat (10) @(negedge clk);

        send(1, 8'h55);
        capture(162);
        check_wave("db7", 1, {1'b1, 1'b1, 7'h55, 1'b0}, 10);
        check("db7_rx_data", rx_data7, 7'h55);
        check("db7_rx_rdy", rx_rdy7, 1);
        check("db7_ferr", frame_err7, 0);
        check("db7_perr", parity_err7, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
